// File: rtl/management_rx_buffer_pkg.sv
// Shared types and constants for the management receive buffer.
// Holds the write-FSM state encoding and the frame-length width.
package management_rx_buffer_pkg;

    localparam int LEN_W  = 11;
    localparam int DROP_W = 16;

    localparam logic [LEN_W-1:0]  LEN_MAX  = 11'd2047;
    localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        DISCARD   = 2'd2
    } wr_state_e;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == DROP_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/management_rx_ram.sv
// Simple dual-port byte store with a one-cycle registered read port.
// Array contents are deliberately left unreset; only the read register clears.
module management_rx_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rdata_r;

    // Write port
    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/management_rx_buffer.sv
// Frame receive buffer: bytes land in a circular store, committed frame lengths
// queue in a small header FIFO, and the reader drains whole frames.
module management_rx_buffer
    import management_rx_buffer_pkg::*;
#(
    parameter int DATA_DEPTH = 4096,
    parameter int HDR_DEPTH  = 32
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             rx_start,
    input  logic             rx_data_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_commit,
    input  logic             rx_drop,
    output logic             rd_frame_valid,
    output logic [LEN_W-1:0] rd_frame_len,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_data_valid,
    input  logic             rd_pop,
    output logic [15:0]      drop_count
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = $clog2(HDR_DEPTH);

    wr_state_e         state_r, state_next_s;
    logic [PW-1:0]     wr_ptr_r, wr_ptr_next_s, commit_ptr_r, rd_base_r;
    logic [LEN_W-1:0]  len_r, len_next_s, rd_off_r;
    logic [HW-1:0]     hdr_wr_r, hdr_rd_r;
    logic [HW:0]       hdr_cnt_r, hdr_cnt_next_s;
    logic [LEN_W-1:0]  hdr_mem_r [HDR_DEPTH];
    logic [DROP_W-1:0] drop_count_r;
    logic              rd_frame_valid_r, rd_data_valid_r;

    logic              ram_we_s, push_s, commit_s, drop_inc_s;
    logic              hdr_full_s, buf_full_s, has_frame_s, pop_s, rd_accept_s;
    logic [LEN_W-1:0]  head_len_s;
    logic [PW-1:0]     rd_sum_s;

    assign hdr_full_s  = (hdr_cnt_r == (HW+1)'(HDR_DEPTH));
    assign buf_full_s  = ((wr_ptr_r - rd_base_r) == PW'(DATA_DEPTH));
    assign has_frame_s = (hdr_cnt_r != '0);
    assign head_len_s  = hdr_mem_r[hdr_rd_r];
    assign pop_s       = rd_pop & has_frame_s;
    assign rd_accept_s = rd_en & has_frame_s & ~rd_pop & (rd_off_r < head_len_s);
    assign rd_sum_s    = rd_base_r + PW'(rd_off_r);

    // Write FSM: next state, write pointer, length and side effects
    always_comb begin
        state_next_s  = state_r;
        wr_ptr_next_s = wr_ptr_r;
        len_next_s    = len_r;
        ram_we_s      = 1'b0;
        push_s        = 1'b0;
        commit_s      = 1'b0;
        drop_inc_s    = 1'b0;
        if (rx_start) begin
            // A new start always abandons whatever was in flight
            wr_ptr_next_s = commit_ptr_r;
            len_next_s    = '0;
            if (hdr_full_s) begin
                state_next_s = DISCARD;
                drop_inc_s   = 1'b1;
            end else begin
                state_next_s = RECEIVING;
            end
        end else begin
            case (state_r)
                RECEIVING: begin
                    if (rx_commit) begin
                        commit_s     = 1'b1;
                        push_s       = (len_r != '0);
                        state_next_s = IDLE;
                    end else if (rx_drop) begin
                        wr_ptr_next_s = commit_ptr_r;
                        state_next_s  = IDLE;
                    end else if (rx_data_valid) begin
                        if (buf_full_s || (len_r == LEN_MAX)) begin
                            wr_ptr_next_s = commit_ptr_r;
                            state_next_s  = DISCARD;
                            drop_inc_s    = 1'b1;
                        end else begin
                            ram_we_s      = 1'b1;
                            wr_ptr_next_s = wr_ptr_r + PW'(1'b1);
                            len_next_s    = len_r + 11'd1;
                        end
                    end else begin
                        state_next_s = RECEIVING;
                    end
                end
                DISCARD: begin
                    if (rx_commit || rx_drop) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DISCARD;
                    end
                end
                IDLE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Header queue occupancy after this cycle's push and pop
    always_comb begin
        hdr_cnt_next_s = hdr_cnt_r;
        case ({push_s, pop_s})
            2'b10:   hdr_cnt_next_s = hdr_cnt_r + (HW+1)'(1'b1);
            2'b01:   hdr_cnt_next_s = hdr_cnt_r - (HW+1)'(1'b1);
            default: hdr_cnt_next_s = hdr_cnt_r;
        endcase
    end

    // Control state, pointers and counters
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            wr_ptr_r         <= '0;
            commit_ptr_r     <= '0;
            rd_base_r        <= '0;
            len_r            <= '0;
            rd_off_r         <= '0;
            hdr_wr_r         <= '0;
            hdr_rd_r         <= '0;
            hdr_cnt_r        <= '0;
            drop_count_r     <= '0;
            rd_frame_valid_r <= 1'b0;
            rd_data_valid_r  <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            wr_ptr_r         <= wr_ptr_next_s;
            len_r            <= len_next_s;
            hdr_cnt_r        <= hdr_cnt_next_s;
            rd_frame_valid_r <= (hdr_cnt_next_s != '0);
            rd_data_valid_r  <= rd_accept_s;
            if (commit_s) begin
                commit_ptr_r <= wr_ptr_r;
            end
            if (push_s) begin
                hdr_wr_r <= hdr_wr_r + HW'(1'b1);
            end
            if (drop_inc_s) begin
                drop_count_r <= sat_inc(drop_count_r);
            end
            if (pop_s) begin
                rd_base_r <= rd_base_r + PW'(head_len_s);
                rd_off_r  <= '0;
                hdr_rd_r  <= hdr_rd_r + HW'(1'b1);
            end else if (rd_accept_s) begin
                rd_off_r <= rd_off_r + 11'd1;
            end
        end
    end

    // Header queue storage
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            hdr_mem_r[hdr_wr_r] <= len_r;
        end
    end

    management_rx_ram #(
        .DEPTH (DATA_DEPTH),
        .AW    (AW)
    ) u_ram (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .we      (ram_we_s),
        .waddr   (wr_ptr_r[AW-1:0]),
        .wdata   (rx_data),
        .re      (rd_accept_s),
        .raddr   (rd_sum_s[AW-1:0]),
        .rdata   (rd_data)
    );

    assign rd_frame_valid = rd_frame_valid_r;
    assign rd_frame_len   = rd_frame_valid_r ? head_len_s : '0;
    assign rd_data_valid  = rd_data_valid_r;
    assign drop_count     = drop_count_r;

endmodule
